// File: rtl/imem_responder.sv
// Instruction-memory responder: PC-addressed fetch with fixed latency.
// Optional build macro IMEM_OOR_EBREAK_EN: error fetches return ebreak.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

`ifdef IMEM_OOR_EBREAK_EN
    localparam logic [31:0] ERR_INST = 32'h0010_0073;
`else
    localparam logic [31:0] ERR_INST = 32'h0000_0000;
`endif

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Offsets are plain 32-bit differences; below-base addresses wrap
    // high, so the explicit >= check is what rejects them.
    logic [31:0]   rd_off, ld_off;
    logic          rd_ok, ld_ok;
    logic [IW-1:0] rd_idx, ld_idx;

    assign rd_off = addr_q - BASE_ADDR;
    assign rd_idx = rd_off[IW+1:2];
    assign rd_ok  = (addr_q >= BASE_ADDR)
                 && ((rd_off >> 2) < 32'(DEPTH_WORDS))
                 && (addr_q[1:0] == 2'b00);

    assign ld_off = load_addr - BASE_ADDR;
    assign ld_idx = ld_off[IW+1:2];
    assign ld_ok  = (load_addr >= BASE_ADDR)
                 && ((ld_off >> 2) < 32'(DEPTH_WORDS))
                 && (load_addr[1:0] == 2'b00);

    assign resp_inst = inst_q;
    assign resp_err  = err_q;

    // Image write port; the response register samples the old word on a
    // same-edge collision, so reads see data from before the write.
    always_ff @(posedge clk) begin
        if (load_en && ld_ok) begin
            mem_q[ld_idx] <= load_data;
        end
    end

    // Control and response registers; reset drops any in-flight fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            inst_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept, count down the latency, then hold response.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        err_d      = err_q;
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = !rd_ok;
                    inst_d  = rd_ok ? mem_q[rd_idx] : ERR_INST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
